data_mem_arbiter: RTL and testbench
===================================

Name: data_mem_arbiter

Overview:
Two-port arbiter/sequencer in front of the single-port data memory (Clk, address, data-in, we, re, data-out). Shares the memory between requester 0 (CPU load/store path) and requester 1 (program/data loader or debug port), using round-robin grant with a valid/ready handshake. It issues exactly one memory strobe per transaction, waits out the memory read latency, and returns read data with a one-cycle ready pulse.

Parameters:
ADDR_W, 32, width of request and memory address
DATA_W, 32, width of write/read data
RD_LAT, 1, cycles from the memory re strobe until mem_dout is valid (0 to 7 supported)

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  synchronous, active-high reset
req0_valid  in  1  requester 0 has a pending access; held until req0_ready
req0_we  in  1  1 = write, 0 = read; stable while valid
req0_addr  in  ADDR_W  access address; stable while valid
req0_wdata  in  DATA_W  write data; stable while valid
req0_ready  out  1  one-cycle completion pulse
req0_rdata  out  DATA_W  read result; valid while req0_ready is high
req1_valid, req1_we, req1_addr, req1_wdata, req1_ready, req1_rdata: same as above, for requester 1
mem_addr  out  ADDR_W  to memory address
mem_din  out  DATA_W  to memory data-in
mem_we  out  1  memory write strobe
mem_re  out  1  memory read strobe
mem_dout  in  DATA_W  from memory data-out
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset: state=IDLE, rr_ptr=0 (requester 0 wins a tie), mem_we=0, mem_re=0, mem_addr=0, mem_din=0, req*_ready=0, req*_rdata=0, busy=0.
- All outputs are registered. mem_we and mem_re are never both high.
- IDLE: if no valid, stay. If only one valid, grant it. If both valid, grant rr_ptr. On grant, latch id, we, addr and wdata, then go to ACCESS.
- ACCESS (1 cycle): mem_addr and mem_din show the latched values. mem_we=1 for a write, mem_re=1 for a read.
  - Write: go to RESP.
  - Read with RD_LAT=0: capture mem_dout at the end of ACCESS, then go to RESP.
  - Read with RD_LAT>0: go to WAIT.
- WAIT: strobes are low. A down-counter is loaded with RD_LAT-1. Capture mem_dout at the edge that ends the last WAIT cycle, then go to RESP.
- RESP (1 cycle):
  - The granted reqN_ready=1.
  - reqN_rdata = captured data for a read, 0 for a write. The other requester's ready stays 0.
  - rr_ptr = the non-granted id. Next state is IDLE.
- reqN_rdata holds its last value after RESP.
- mem_addr and mem_din hold their last values outside ACCESS.
- Latency from valid sampled in IDLE to ready: write = 2 cycles; read = 2+RD_LAT cycles.
- The requester drops valid on the edge ending its ready cycle. The next IDLE cycle therefore sees only fresh requests.
- Fairness: with both requesters continuously valid, grants strictly alternate. Each requester waits at most one foreign transaction.
- valid asserted while busy is held pending. It is not dropped and not served mid-transaction.
- Input changes on a granted requester after the grant have no effect, because the values are latched.
- Reset mid-transaction (any state): abandon it. No ready is issued, and strobes are 0 from the next cycle.
- Reset asserted in the same cycle as a valid: reset wins and no grant occurs.

Test Plan:
- Reset release, no valid for 5 cycles -> busy=0, mem_we=mem_re=0, both ready=0, mem_addr=0.
- req0 write addr=0x0, wdata=0xFFFFFFFF -> mem_we=1 for exactly 1 cycle with mem_addr=0x0 and mem_din=0xFFFFFFFF; req0_ready pulses 2 cycles after grant; req0_rdata=0.
- req0 read addr=0x0 after that write, RD_LAT=1, memory model returns 0xFFFFFFFF one cycle after re -> mem_re=1 for 1 cycle; req0_ready=1 with req0_rdata=0xFFFFFFFF, 3 cycles after the IDLE sample.
- req0 and req1 both held valid (writes to 0x4 and 0x8, data 0x11111111 and 0x22222222) -> grant order req0, req1, req0, ...; each ready is a single cycle; memory holds the last written values.
- req1 read of 0x8 in flight, Reset pulsed during WAIT -> no req1_ready, state=IDLE, busy=0, rr_ptr=0 the following cycle; a reissued read completes normally.
- RD_LAT=0 and RD_LAT=3 builds, read of 0x4 -> ready arrives at 2 and 5 cycles respectively with data 0x11111111.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter that shares a single-port data memory between two
// valid/ready requesters, issuing one strobe per access and absorbing read latency.
module data_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic [DATA_W-1:0] req0_rdata,
    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic [DATA_W-1:0] req1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    // Handshake: a requester holds valid and its fields stable until it sees a
    // one-cycle ready; it drops valid on the edge that ends the ready cycle.
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

    localparam int         WAIT_LOAD = (RD_LAT > 0) ? RD_LAT - 1 : 0;
    localparam logic [2:0] WAIT_INIT = WAIT_LOAD[2:0];

    state_t              state;
    logic                rr_ptr;
    logic                gnt_id;
    logic                gnt_we;
    logic [2:0]          cnt;

    logic                any_valid;
    logic                pick;
    logic                pick_we;
    logic [ADDR_W-1:0]   pick_addr;
    logic [DATA_W-1:0]   pick_wdata;
    logic                finish;
    logic [DATA_W-1:0]   fin_data;

    assign dbg_state = state;

    always_comb begin
        any_valid  = req0_valid | req1_valid;
        pick       = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
        pick_we    = pick ? req1_we    : req0_we;
        pick_addr  = pick ? req1_addr  : req0_addr;
        pick_wdata = pick ? req1_wdata : req0_wdata;
        finish     = 1'b0;
        fin_data   = '0;
        // finish marks the edge that moves into RESP; fin_data is what the requester sees
        case (state)
            ACCESS: begin
                if (gnt_we) begin
                    finish = 1'b1;
                end else if (RD_LAT == 0) begin
                    finish   = 1'b1;
                    fin_data = mem_dout;
                end
            end
            WAIT: begin
                if (cnt == 3'd0) begin
                    finish   = 1'b1;
                    fin_data = mem_dout;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            rr_ptr     <= 1'b0;
            gnt_id     <= 1'b0;
            gnt_we     <= 1'b0;
            cnt        <= 3'd0;
            mem_addr   <= '0;
            mem_din    <= '0;
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            req0_rdata <= '0;
            req1_rdata <= '0;
            busy       <= 1'b0;
        end else begin
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        gnt_id   <= pick;
                        gnt_we   <= pick_we;
                        mem_addr <= pick_addr;
                        mem_din  <= pick_wdata;
                        mem_we   <= pick_we;
                        mem_re   <= ~pick_we;
                        busy     <= 1'b1;
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (finish) begin
                        state <= RESP;
                    end else begin
                        state <= WAIT;
                        cnt   <= WAIT_INIT;
                    end
                end
                WAIT: begin
                    if (finish) state <= RESP;
                    else        cnt   <= cnt - 3'd1;
                end
                RESP: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    rr_ptr <= ~gnt_id;
                end
                default: state <= IDLE;
            endcase
            if (finish) begin
                if (gnt_id) begin
                    req1_ready <= 1'b1;
                    req1_rdata <= fin_data;
                end else begin
                    req0_ready <= 1'b1;
                    req0_rdata <= fin_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: three builds (RD_LAT 0, 1, 3) share the request
// stimulus, each with its own memory model; most checks look at the RD_LAT=1 build.
module tb_data_mem_arbiter;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        req0_valid, req0_we, req1_valid, req1_we;
    logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;

    logic        r0_ready [3];
    logic        r1_ready [3];
    logic        m_we     [3];
    logic        m_re     [3];
    logic        bsy      [3];
    logic [1:0]  st       [3];
    logic [31:0] r0_rdata [3];
    logic [31:0] r1_rdata [3];
    logic [31:0] m_addr   [3];
    logic [31:0] m_din    [3];
    logic [31:0] m_dout   [3];

    logic [31:0] mem_arr [3][16];
    logic [31:0] pipe    [3][3];

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        for (int i = 0; i < 3; i++) begin
            if (m_we[i]) mem_arr[i][m_addr[i][5:2]] <= m_din[i];
            pipe[i][0] <= mem_arr[i][m_addr[i][5:2]];
            pipe[i][1] <= pipe[i][0];
            pipe[i][2] <= pipe[i][1];
        end
    end

    assign m_dout[0] = mem_arr[0][m_addr[0][5:2]];
    assign m_dout[1] = pipe[1][0];
    assign m_dout[2] = pipe[2][2];

    data_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(0)) dut_l0 (
        .Clk(Clk), .Reset(Reset),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req0_ready(r0_ready[0]), .req0_rdata(r0_rdata[0]),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req1_ready(r1_ready[0]), .req1_rdata(r1_rdata[0]),
        .mem_addr(m_addr[0]), .mem_din(m_din[0]), .mem_we(m_we[0]), .mem_re(m_re[0]),
        .mem_dout(m_dout[0]), .busy(bsy[0]), .dbg_state(st[0])
    );

    data_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1)) dut_l1 (
        .Clk(Clk), .Reset(Reset),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req0_ready(r0_ready[1]), .req0_rdata(r0_rdata[1]),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req1_ready(r1_ready[1]), .req1_rdata(r1_rdata[1]),
        .mem_addr(m_addr[1]), .mem_din(m_din[1]), .mem_we(m_we[1]), .mem_re(m_re[1]),
        .mem_dout(m_dout[1]), .busy(bsy[1]), .dbg_state(st[1])
    );

    data_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3)) dut_l3 (
        .Clk(Clk), .Reset(Reset),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req0_ready(r0_ready[2]), .req0_rdata(r0_rdata[2]),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req1_ready(r1_ready[2]), .req1_rdata(r1_rdata[2]),
        .mem_addr(m_addr[2]), .mem_din(m_din[2]), .mem_we(m_we[2]), .mem_re(m_re[2]),
        .mem_dout(m_dout[2]), .busy(bsy[2]), .dbg_state(st[2])
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset      = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        Reset      = 1'b1;
        req0_valid = 1'b1;
        req0_we    = 1'b1;
        req0_addr  = 32'h10;
        req0_wdata = 32'hA5A5A5A5;
        tick();
        tick();
        checks++;
        if (bsy[1] !== 1'b0 || m_we[1] !== 1'b0 || st[1] !== 2'd0) begin
            errors++;
            $display("FAIL reset_with_valid: busy=%0b mem_we=%0b state=%0d expected 0 0 0", bsy[1], m_we[1], st[1]);
        end
        Reset      = 1'b0;
        req0_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            checks++;
            if ({bsy[1], m_we[1], m_re[1], r0_ready[1], r1_ready[1]} !== 5'b0 ||
                m_addr[1] !== 32'h0 || m_din[1] !== 32'h0 || r0_rdata[1] !== 32'h0 || st[1] !== 2'd0) begin
                errors++;
                $display("FAIL reset_idle c%0d: busy/we/re/rdy0/rdy1=%b addr=%h din=%h rdata0=%h state=%0d expected all zero",
                         c, {bsy[1], m_we[1], m_re[1], r0_ready[1], r1_ready[1]}, m_addr[1], m_din[1], r0_rdata[1], st[1]);
            end
        end
    endtask

    task automatic test_write();
        do_reset();
        req0_we    = 1'b1;
        req0_addr  = 32'h0;
        req0_wdata = 32'hFFFFFFFF;
        req0_valid = 1'b1;
        tick();
        checks++;
        if (m_we[1] !== 1'b1 || m_re[1] !== 1'b0 || m_addr[1] !== 32'h0 || m_din[1] !== 32'hFFFFFFFF ||
            r0_ready[1] !== 1'b0 || bsy[1] !== 1'b1) begin
            errors++;
            $display("FAIL write_access: we=%0b re=%0b addr=%h din=%h rdy0=%0b busy=%0b expected 1 0 0 ffffffff 0 1",
                     m_we[1], m_re[1], m_addr[1], m_din[1], r0_ready[1], bsy[1]);
        end
        req0_wdata = 32'h12345678;
        tick();
        checks++;
        if (m_we[1] !== 1'b0 || r0_ready[1] !== 1'b1 || r0_rdata[1] !== 32'h0 || r1_ready[1] !== 1'b0) begin
            errors++;
            $display("FAIL write_resp: we=%0b rdy0=%0b rdata0=%h rdy1=%0b expected 0 1 0 0",
                     m_we[1], r0_ready[1], r0_rdata[1], r1_ready[1]);
        end
        req0_valid = 1'b0;
        tick();
        checks++;
        if (r0_ready[1] !== 1'b0 || bsy[1] !== 1'b0 || m_din[1] !== 32'hFFFFFFFF || mem_arr[1][0] !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL write_after: rdy0=%0b busy=%0b din=%h mem[0]=%h expected 0 0 ffffffff ffffffff",
                     r0_ready[1], bsy[1], m_din[1], mem_arr[1][0]);
        end
    endtask

    task automatic test_read();
        do_reset();
        req0_we    = 1'b0;
        req0_addr  = 32'h0;
        req0_valid = 1'b1;
        tick();
        checks++;
        if (m_re[1] !== 1'b1 || m_we[1] !== 1'b0 || m_addr[1] !== 32'h0 || st[1] !== 2'd1) begin
            errors++;
            $display("FAIL read_access: re=%0b we=%0b addr=%h state=%0d expected 1 0 0 1", m_re[1], m_we[1], m_addr[1], st[1]);
        end
        tick();
        checks++;
        if (m_re[1] !== 1'b0 || r0_ready[1] !== 1'b0 || st[1] !== 2'd2 || bsy[1] !== 1'b1) begin
            errors++;
            $display("FAIL read_wait: re=%0b rdy0=%0b state=%0d busy=%0b expected 0 0 2 1", m_re[1], r0_ready[1], st[1], bsy[1]);
        end
        tick();
        checks++;
        if (r0_ready[1] !== 1'b1 || r0_rdata[1] !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL read_resp: rdy0=%0b rdata0=%h expected 1 ffffffff", r0_ready[1], r0_rdata[1]);
        end
        req0_valid = 1'b0;
        tick();
        checks++;
        if (r0_ready[1] !== 1'b0 || r0_rdata[1] !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL read_hold: rdy0=%0b rdata0=%h expected 0 ffffffff", r0_ready[1], r0_rdata[1]);
        end
    endtask

    task automatic test_round_robin();
        logic e0, e1, ew;
        do_reset();
        req0_we    = 1'b1;
        req0_addr  = 32'h4;
        req0_wdata = 32'h11111111;
        req1_we    = 1'b1;
        req1_addr  = 32'h8;
        req1_wdata = 32'h22222222;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            e0 = (c == 2) || (c == 8);
            e1 = (c == 5) || (c == 11);
            ew = (c == 1) || (c == 4) || (c == 7) || (c == 10);
            checks++;
            if (r0_ready[1] !== e0 || r1_ready[1] !== e1) begin
                errors++;
                $display("FAIL rr_ready c%0d: rdy0=%0b rdy1=%0b expected %0b %0b", c, r0_ready[1], r1_ready[1], e0, e1);
            end
            checks++;
            if (m_we[1] !== ew || (ew && m_addr[1] !== ((c == 1 || c == 7) ? 32'h4 : 32'h8))) begin
                errors++;
                $display("FAIL rr_strobe c%0d: we=%0b addr=%h expected we=%0b", c, m_we[1], m_addr[1], ew);
            end
            if (c == 11) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
        end
        tick();
        checks++;
        if (mem_arr[1][1] !== 32'h11111111 || mem_arr[1][2] !== 32'h22222222 || r1_rdata[1] !== 32'h0) begin
            errors++;
            $display("FAIL rr_memory: mem[4]=%h mem[8]=%h rdata1=%h expected 11111111 22222222 0",
                     mem_arr[1][1], mem_arr[1][2], r1_rdata[1]);
        end
    endtask

    task automatic test_reset_mid();
        int t0, t1;
        logic [31:0] d0, d1;
        do_reset();
        req1_we    = 1'b0;
        req1_addr  = 32'h8;
        req1_valid = 1'b1;
        tick();
        tick();
        checks++;
        if (st[1] !== 2'd2) begin
            errors++;
            $display("FAIL mid_in_wait: state=%0d expected 2", st[1]);
        end
        Reset      = 1'b1;
        req1_valid = 1'b0;
        tick();
        Reset = 1'b0;
        checks++;
        if (r1_ready[1] !== 1'b0 || bsy[1] !== 1'b0 || st[1] !== 2'd0 || m_re[1] !== 1'b0) begin
            errors++;
            $display("FAIL mid_abandon: rdy1=%0b busy=%0b state=%0d re=%0b expected 0 0 0 0", r1_ready[1], bsy[1], st[1], m_re[1]);
        end
        tick();
        checks++;
        if (r1_ready[1] !== 1'b0 || bsy[1] !== 1'b0) begin
            errors++;
            $display("FAIL mid_quiet: rdy1=%0b busy=%0b expected 0 0", r1_ready[1], bsy[1]);
        end
        t0 = -1;
        t1 = -1;
        d0 = '0;
        d1 = '0;
        req0_we    = 1'b0;
        req0_addr  = 32'h4;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (r0_ready[1] && t0 < 0) begin
                t0 = c;
                d0 = r0_rdata[1];
                req0_valid = 1'b0;
            end
            if (r1_ready[1] && t1 < 0) begin
                t1 = c;
                d1 = r1_rdata[1];
                req1_valid = 1'b0;
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        checks++;
        if (t0 !== 3 || d0 !== 32'h11111111) begin
            errors++;
            $display("FAIL mid_reissue_req0: cycle=%0d data=%h expected 3 11111111", t0, d0);
        end
        checks++;
        if (t1 !== 7 || d1 !== 32'h22222222) begin
            errors++;
            $display("FAIL mid_reissue_req1: cycle=%0d data=%h expected 7 22222222", t1, d1);
        end
    endtask

    task automatic test_latency();
        int t [3];
        logic [31:0] d [3];
        int exp_t [3];
        exp_t[0] = 2;
        exp_t[1] = 3;
        exp_t[2] = 5;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            t[i] = -1;
            d[i] = '0;
        end
        req0_we    = 1'b0;
        req0_addr  = 32'h4;
        req0_valid = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                if (r0_ready[i] && t[i] < 0) begin
                    t[i] = c;
                    d[i] = r0_rdata[i];
                end
            end
            if (c == 5) req0_valid = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (t[i] !== exp_t[i] || d[i] !== 32'h11111111) begin
                errors++;
                $display("FAIL latency_build%0d: cycle=%0d data=%h expected %0d 11111111", i, t[i], d[i], exp_t[i]);
            end
        end
        do_reset();
    endtask

    initial begin
        Reset      = 1'b1;
        req0_valid = 1'b0;
        req0_we    = 1'b0;
        req0_addr  = '0;
        req0_wdata = '0;
        req1_valid = 1'b0;
        req1_we    = 1'b0;
        req1_addr  = '0;
        req1_wdata = '0;
        test_reset();
        test_write();
        test_read();
        test_round_robin();
        test_reset_mid();
        test_latency();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
